// File: rtl/clk_div_ctrl.sv
// Free-running clock divider and CPU clock controller: fast, slow, debounced
// single-step and hold modes, with glitch-free switching of a flop-driven clk_cpu.
module clk_div_ctrl #(
  parameter int CNT_W    = 32,
  parameter int FAST_BIT = 2,
  parameter int SLOW_BIT = 24,
  parameter int DB_CYC   = 1000000,
  parameter int STEP_HI  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  output logic [CNT_W-1:0] clkdiv,
  output logic             clk_cpu,
  output logic             cpu_en,
  output logic [1:0]       mode_active
);
  localparam int DB_W = $clog2(DB_CYC + 1);
  localparam int ST_W = $clog2(STEP_HI + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(STEP_HI - 1);
  localparam logic [1:0] M_FAST = 2'b00;
  localparam logic [1:0] M_SLOW = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    PARK      = 2'd2,
    STEP_HIGH = 2'd3
  } state_t;

  logic [CNT_W-1:0] clkdiv_q, clkdiv_d;
  logic [1:0]       mode_m_q, mode_s_q;
  logic             btn_m_q, btn_s_q;
  logic             db_level_q, step_req_q;
  logic [DB_W-1:0]  db_cnt_q;
  state_t           state_q;
  logic [1:0]       mode_active_q;
  logic             clk_cpu_q, clk_cpu_d, cpu_en_q;
  logic [ST_W-1:0]  step_cnt_q;
  logic             src_fast, src_slow, src_old, src_new, step_go;

  function automatic logic src_of(input logic [1:0] m, input logic fast, input logic slow);
    case (m)
      M_FAST:  src_of = fast;
      M_SLOW:  src_of = slow;
      default: src_of = 1'b0;
    endcase
  endfunction

  assign clkdiv_d = clkdiv_q + CNT_W'(1);
  assign src_fast = clkdiv_q[FAST_BIT];
  assign src_slow = clkdiv_q[SLOW_BIT];
  assign src_old  = src_of(mode_active_q, src_fast, src_slow);
  assign src_new  = src_of(mode_s_q, src_fast, src_slow);
  assign step_go  = (mode_s_q == mode_active_q) && (mode_active_q == M_STEP) && step_req_q;

  // Free-running divider counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clkdiv_q <= '0;
    else     clkdiv_q <= clkdiv_d;
  end

  // Two-stage synchronisers for the mode switches and the step button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_m_q <= 2'b00;
      mode_s_q <= 2'b00;
      btn_m_q  <= 1'b0;
      btn_s_q  <= 1'b0;
    end else begin
      mode_m_q <= mode;
      mode_s_q <= mode_m_q;
      btn_m_q  <= step_btn;
      btn_s_q  <= btn_m_q;
    end
  end

  // Debounce: accept a new level only after DB_CYC stable cycles; pulse on rising level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      step_req_q <= 1'b0;
      if (btn_s_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_q   <= '0;
        db_level_q <= btn_s_q;
        step_req_q <= btn_s_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // Next CPU clock level; DRAIN keeps following the old source so its high phase ends naturally
  always_comb begin
    clk_cpu_d = 1'b0;
    case (state_q)
      RUN: begin
        if (step_go) clk_cpu_d = 1'b1;
        else         clk_cpu_d = src_old;
      end
      DRAIN: clk_cpu_d = src_old;
      PARK:  clk_cpu_d = 1'b0;
      STEP_HIGH: begin
        if (step_cnt_q == STEP_LAST) clk_cpu_d = 1'b0;
        else                         clk_cpu_d = 1'b1;
      end
      default: clk_cpu_d = 1'b0;
    endcase
  end

  // Output FSM with registered clk_cpu, cpu_en and mode_active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      mode_active_q <= M_FAST;
      clk_cpu_q     <= 1'b0;
      cpu_en_q      <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      clk_cpu_q <= clk_cpu_d;
      cpu_en_q  <= clk_cpu_d & ~clk_cpu_q;
      case (state_q)
        RUN: begin
          if (mode_s_q != mode_active_q) begin
            state_q <= DRAIN;
          end else if (step_go) begin
            state_q    <= STEP_HIGH;
            step_cnt_q <= '0;
          end else begin
            state_q <= RUN;
          end
        end
        DRAIN: begin
          if (!src_old) state_q <= PARK;
          else          state_q <= DRAIN;
        end
        PARK: begin
          // Re-loaded every cycle so a mode change while parked takes the latest request
          mode_active_q <= mode_s_q;
          if (!src_new) state_q <= RUN;
          else          state_q <= PARK;
        end
        STEP_HIGH: begin
          if (step_cnt_q == STEP_LAST) state_q <= RUN;
          else                         step_cnt_q <= step_cnt_q + ST_W'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign clkdiv      = clkdiv_q;
  assign clk_cpu     = clk_cpu_q;
  assign cpu_en      = cpu_en_q;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: small-parameter build (8-bit counter) plus a
// long-step instance used to check that a press during the step pulse is dropped.
module tb_clk_div_ctrl;
  localparam int CW = 8;
  localparam int FB = 2;
  localparam int SB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic step_btn = 1'b0;
  logic step_btn_b = 1'b0;
  logic [CW-1:0] clkdiv, clkdiv_b;
  logic clk_cpu, cpu_en, clk_cpu_b, cpu_en_b;
  logic [1:0] mode_active, mode_active_b;
  logic [CW-1:0] model_cnt;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [CW-1:0] div;
    logic          cpu;
    logic          en;
    logic [1:0]    ma;
  } obs_t;

  obs_t sb[$];
  int   wq[$];

  clk_div_ctrl #(.CNT_W(CW), .FAST_BIT(FB), .SLOW_BIT(SB), .DB_CYC(4), .STEP_HI(3)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .clkdiv(clkdiv),
    .clk_cpu(clk_cpu), .cpu_en(cpu_en), .mode_active(mode_active));

  clk_div_ctrl #(.CNT_W(CW), .FAST_BIT(FB), .SLOW_BIT(SB), .DB_CYC(4), .STEP_HI(16)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn_b), .clkdiv(clkdiv_b),
    .clk_cpu(clk_cpu_b), .cpu_en(cpu_en_b), .mode_active(mode_active_b));

  always #5 clk = ~clk;

  // Reference count of clk edges since the last reset
  always @(posedge clk or posedge rst) begin
    if (rst) model_cnt <= '0;
    else     model_cnt <= model_cnt + 8'd1;
  end

  // Expected outputs while clk_cpu follows counter bit b with one clk of lag
  function automatic obs_t exp_follow(input int b, input logic [1:0] ma);
    logic [CW-1:0] p1, p2;
    obs_t e;
    p1 = model_cnt - 8'd1;
    p2 = model_cnt - 8'd2;
    e.div = model_cnt;
    e.cpu = p1[b];
    e.en  = p1[b] & ~p2[b];
    e.ma  = ma;
    return e;
  endfunction

  function automatic obs_t obs_main();
    return {clkdiv, clk_cpu, cpu_en, mode_active};
  endfunction

  task automatic push_follow(input int b, input logic [1:0] ma);
    @(posedge clk);
    #1;
    sb.push_back(exp_follow(b, ma));
    @(negedge clk);
  endtask

  task automatic wait_ma(input logic [1:0] m, input bit use_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if ((use_b ? mode_active_b : mode_active) == m) ok = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int budget, output int width, output int en_seen);
    bit done;
    done = 1'b0; width = 0; en_seen = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (cpu_en) en_seen++;
      if (clk_cpu) width++;
      else if (width > 0) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    obs_t a, e;
    repeat (3) @(negedge clk);
    e = '0;
    a = obs_main();
    checks++;
    if (a !== e) begin failures++; $display("FAIL reset_main actual=%h required=%h", a, e); end
    checks++;
    if ({clkdiv_b, clk_cpu_b, cpu_en_b, mode_active_b} !== 12'h000) begin
      failures++; $display("FAIL reset_b actual=%h required=000", {clkdiv_b, clk_cpu_b, cpu_en_b, mode_active_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_fast();
    obs_t a, e;
    for (int i = 0; i < 40; i++) begin
      push_follow(FB, 2'b00);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL fast_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_mode_switch();
    obs_t a, e;
    bit seen, hi;
    int w, en, wd;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (cpu_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL switch_find_edge actual=0 required=1"); end
    mode = 2'b01;
    wq.push_back(4);
    w = 1; hi = 1'b1;
    for (int n = 0; n < 20 && hi; n++) begin
      @(negedge clk);
      if (clk_cpu) w++;
      else hi = 1'b0;
    end
    wd = wq.pop_front(); checks++;
    if (w != wd) begin failures++; $display("FAIL switch_last_fast_width actual=%0d required=%0d", w, wd); end
    for (int k = 0; k < 2; k++) begin
      wq.push_back(16);
      wait_pulse(120, w, en);
      wd = wq.pop_front(); checks++;
      if (w != wd || en != 1) begin
        failures++; $display("FAIL slow_pulse k=%0d width=%0d en=%0d required width=%0d en=1", k, w, en, wd);
      end
    end
    checks++;
    if (mode_active !== 2'b01) begin failures++; $display("FAIL switch_mode_active actual=%b required=01", mode_active); end
    for (int i = 0; i < 40; i++) begin
      push_follow(SB, 2'b01);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL slow_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_step();
    bit ok;
    int hi_cnt, en_cnt, wd;
    mode = 2'b10;
    wait_ma(2'b10, 1'b0, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL step_enter actual=%b required=10", mode_active); end
    wq.push_back(3);
    hi_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clk_cpu) hi_cnt++;
      if (cpu_en) en_cnt++;
      step_btn = (i < 10);
    end
    wd = wq.pop_front(); checks++;
    if (hi_cnt != wd) begin failures++; $display("FAIL step_width actual=%0d required=%0d", hi_cnt, wd); end
    checks++;
    if (en_cnt != 1) begin failures++; $display("FAIL step_en_count actual=%0d required=1", en_cnt); end
  endtask

  task automatic test_bounce();
    int hi_cnt, en_cnt;
    hi_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clk_cpu) hi_cnt++;
      if (cpu_en) en_cnt++;
      step_btn = (i == 2 || i == 3 || i == 12 || i == 13 || i == 22 || i == 23);
    end
    step_btn = 1'b0;
    checks++;
    if (hi_cnt != 0 || en_cnt != 0) begin
      failures++; $display("FAIL bounce_pulse high=%0d en=%0d required 0/0", hi_cnt, en_cnt);
    end
  endtask

  task automatic test_step_ignore();
    bit ok, seen;
    int hi_cnt, en_cnt, k, wd;
    wait_ma(2'b10, 1'b1, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ignore_enter actual=%b required=10", mode_active_b); end
    wq.push_back(16);
    hi_cnt = 0; en_cnt = 0; seen = 1'b0; k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (clk_cpu_b) hi_cnt++;
      if (cpu_en_b) en_cnt++;
      if (!seen && cpu_en_b) seen = 1'b1;
      if (seen) begin
        step_btn_b = (k >= 5 && k < 13);
        k++;
      end else begin
        step_btn_b = 1'b1;
      end
    end
    step_btn_b = 1'b0;
    wd = wq.pop_front(); checks++;
    if (hi_cnt != wd || en_cnt != 1) begin
      failures++; $display("FAIL ignore_during_step high=%0d en=%0d required %0d/1", hi_cnt, en_cnt, wd);
    end
  endtask

  task automatic test_hold_return();
    obs_t a, e;
    bit ok;
    int w, en, wd;
    mode = 2'b11;
    wait_ma(2'b11, 1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_enter actual=%b required=11", mode_active); end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      sb.push_back({model_cnt, 1'b0, 1'b0, 2'b11});
      @(negedge clk);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL hold_quiet i=%0d actual=%h required=%h", i, a, e); end
      step_btn = (i >= 20 && i < 40);
    end
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    mode = 2'b00;
    wq.push_back(4);
    wait_pulse(60, w, en);
    wd = wq.pop_front(); checks++;
    if (w != wd || en != 1) begin
      failures++; $display("FAIL hold_return_pulse width=%0d en=%0d required %0d/1", w, en, wd);
    end
    for (int i = 0; i < 24; i++) begin
      push_follow(FB, 2'b00);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL return_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid_step();
    obs_t a, e;
    bit ok, seen;
    mode = 2'b10;
    wait_ma(2'b10, 1'b0, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstep_enter actual=%b required=10", mode_active); end
    step_btn = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (clk_cpu) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstep_pulse_start actual=0 required=1"); end
    @(negedge clk);
    rst = 1'b1; mode = 2'b00; step_btn = 1'b0;
    #1;
    e = '0; a = obs_main(); checks++;
    if (a !== e) begin failures++; $display("FAIL rstep_immediate actual=%h required=%h", a, e); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_follow(FB, 2'b00);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL rstep_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid_slow();
    obs_t a, e;
    bit ok, seen;
    mode = 2'b01;
    wait_ma(2'b01, 1'b0, 150, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rslow_enter actual=%b required=01", mode_active); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (clk_cpu) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rslow_high actual=0 required=1"); end
    repeat (5) @(negedge clk);
    rst = 1'b1; mode = 2'b00;
    #1;
    e = '0; a = obs_main(); checks++;
    if (a !== e) begin failures++; $display("FAIL rslow_immediate actual=%h required=%h", a, e); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_follow(FB, 2'b00);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL rslow_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_wrap();
    obs_t a, e;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (model_cnt == 8'd248) ok = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      push_follow(FB, 2'b00);
      e = sb.pop_front(); a = obs_main(); checks++;
      if (a !== e) begin failures++; $display("FAIL wrap_follow i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_mode_switch();
    test_step();
    test_bounce();
    test_step_ignore();
    test_hold_return();
    test_reset_mid_step();
    test_reset_mid_slow();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
